add16_arbiter: RTL and testbench

ADD16_ARBITER -- requirements
Module: add16_arbiter

---
 rtl/add16_arbiter.sv | 132 +++++++++++++
 tb/tb_add16_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add16_arbiter.sv
// Two-requester front end for one shared external 16-bit adder: IDLE/EXEC/RESP FSM with latched response.
// Define ADD16_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module add16_arbiter #(
    parameter int LAST_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_cin,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [15:0] resp_sum,
    output logic        resp_cout,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_gnt;
    logic [15:0] r_op_a;
    logic [15:0] r_op_b;
    logic        r_op_cin;
    logic [15:0] r_sum;
    logic        r_cout;

    logic        w_any_req;
    logic        w_grant;
    logic        w_gnt_idx;
    logic        w_resp_done;
    logic [15:0] w_a [2];
    logic [15:0] w_b [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign w_a[gi]        = req_a[16*gi +: 16];
            assign w_b[gi]        = req_b[16*gi +: 16];
            assign req_ready[gi]  = w_grant && (w_gnt_idx == 1'(gi));
            assign resp_valid[gi] = (r_state == ST_RESP) && (r_gnt == 1'(gi));
        end
    endgenerate

    assign w_any_req   = |req_valid;
    assign w_grant     = (r_state == ST_IDLE) && w_any_req;
    // Only the granted requester's resp_ready can close the handshake.
    assign w_resp_done = (r_state == ST_RESP) && resp_ready[r_gnt];

`ifdef ADD16_ARB_RR_EN
    logic r_last;

    always_comb begin
        if (req_valid == 2'b11) begin
            w_gnt_idx = ~r_last;
        end else begin
            w_gnt_idx = req_valid[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= (LAST_INIT != 0);
        end else if (w_grant) begin
            r_last <= w_gnt_idx;
        end
    end
`else
    assign w_gnt_idx = ~req_valid[0];
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_state_next = ST_EXEC;
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: if (w_resp_done) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_cin <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt    <= w_gnt_idx;
                r_op_a   <= w_a[w_gnt_idx];
                r_op_b   <= w_b[w_gnt_idx];
                r_op_cin <= req_cin[w_gnt_idx];
            end
            // The external adder settles from the operand registers during EXEC.
            if (r_state == ST_EXEC) begin
                r_sum  <= add_sum;
                r_cout <= add_cout;
            end
        end
    end

    assign add_a     = r_op_a;
    assign add_b     = r_op_b;
    assign add_cin   = r_op_cin;
    assign resp_sum  = r_sum;
    assign resp_cout = r_cout;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_add16_arbiter.sv
// Directed-vector bench for add16_arbiter; models the external adder and checks grants, latency and results.
module tb_add16_arbiter;

`ifdef ADD16_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_cin;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [15:0] resp_sum;
    logic        resp_cout;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Shared adder sitting outside the arbiter.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

    add16_arbiter #(.LAST_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .busy       (busy)
    );

    typedef struct {
        logic [1:0]  v;
        logic [15:0] a0;
        logic [15:0] b0;
        logic        c0;
        logic [15:0] a1;
        logic [15:0] b1;
        logic        c1;
        logic        g_rr;
        logic        g_fx;
        logic [15:0] s0;
        logic        co0;
        logic [15:0] s1;
        logic        co1;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [1:0] oh(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        logic        g;
        logic [15:0] ea;
        logic [15:0] es;
        logic        ec;
        g  = RR ? v.g_rr : v.g_fx;
        ea = g ? v.a1 : v.a0;
        es = g ? v.s1 : v.s0;
        ec = g ? v.co1 : v.co0;
        @(negedge clk);
        req_valid = v.v;
        req_a     = {v.a1, v.a0};
        req_b     = {v.b1, v.b0};
        req_cin   = {v.c1, v.c0};
        #1;
        chk("vec_req_ready", 32'(req_ready), 32'(oh(g)));
        chk("vec_busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        // Scramble inputs while in flight; the result must not change.
        req_valid = 2'b00;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'h1357_9BDF;
        req_cin   = 2'b11;
        #1;
        chk("vec_exec_ready", 32'(req_ready), 32'd0);
        chk("vec_exec_busy", 32'(busy), 32'd1);
        chk("vec_add_a", 32'(add_a), 32'(ea));
        @(negedge clk);
        #1;
        chk("vec_resp_valid", 32'(resp_valid), 32'(oh(g)));
        chk("vec_resp_sum", 32'(resp_sum), 32'(es));
        chk("vec_resp_cout", 32'(resp_cout), 32'(ec));
        resp_ready = 2'b11;
        $display("txn %0d: req_valid=%b grant=%0d sum=%h cout=%b", idx, v.v, g, resp_sum, resp_cout);
        @(negedge clk);
        #1;
        chk("vec_resp_done", 32'(resp_valid), 32'd0);
        chk("vec_back_idle", 32'(busy), 32'd0);
        resp_ready = 2'b00;
    endtask

    initial begin
        //           v      a0       b0       c0    a1       b1       c1    rr    fx    s0       co0   s1       co1
        vecs[0] = '{2'b01, 16'h1234, 16'h0FED, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h2221, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0001, 1'b1};
        vecs[2] = '{2'b11, 16'h0001, 16'h0002, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{2'b11, 16'h00FF, 16'h0001, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0101, 1'b0, 16'h8000, 1'b0};
        vecs[4] = '{2'b01, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 1'b0};
        vecs[5] = '{2'b11, 16'hAAAA, 16'h5555, 1'b0, 16'hAAAA, 16'h5556, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b1};

        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_cin    = 2'b00;
        resp_ready = 2'b00;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_sum", 32'(resp_sum), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_txn(i, vecs[i]);
        end

        // Response held off for five cycles; non-granted resp_ready must be ignored.
        @(negedge clk);
        req_valid = 2'b01;
        req_a     = {16'h0000, 16'h0100};
        req_b     = {16'h0000, 16'h0200};
        req_cin   = 2'b00;
        #1;
        chk("hold_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid  = 2'b11;
        resp_ready = 2'b10;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold_resp_valid", 32'(resp_valid), 32'd1);
            chk("hold_resp_sum", 32'(resp_sum), 32'h0300);
            chk("hold_no_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 2'b01;
        req_valid  = 2'b00;
        #1;
        chk("hold_last_valid", 32'(resp_valid), 32'd1);
        $display("txn hold: grant=0 sum=%h released after 5 stalled cycles", resp_sum);
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("hold_done_valid", 32'(resp_valid), 32'd0);
        chk("hold_done_busy", 32'(busy), 32'd0);

        // Reset during EXEC discards the transaction.
        @(negedge clk);
        req_valid = 2'b10;
        req_a     = {16'h1111, 16'h0000};
        req_b     = {16'h2222, 16'h0000};
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_ready0", 32'(req_ready), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_sum", 32'(resp_sum), 32'd0);
        chk("abort_resp_cout", 32'(resp_cout), 32'd0);
        chk("abort_add_a", 32'(add_a), 32'd0);
        chk("abort_add_b", 32'(add_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        $display("txn abort: reset in EXEC, no response issued");

        // Both requesters valid continuously with resp_ready already high.
        @(negedge clk);
        req_valid  = 2'b11;
        req_a      = {16'h0020, 16'h0010};
        req_b      = {16'h0002, 16'h0001};
        req_cin    = 2'b00;
        resp_ready = 2'b11;
        for (int t = 0; t < 12; t++) begin
            logic g;
            if (t > 0) @(negedge clk);
            #1;
            g = RR ? ((t / 3) % 2 == 0) : 1'b0;
            if (t % 3 == 0) begin
                chk("alt_grant", 32'(req_ready), 32'(oh(g)));
            end else if (t % 3 == 2) begin
                chk("alt_resp_valid", 32'(resp_valid), 32'(oh(g)));
                chk("alt_resp_sum", 32'(resp_sum), g ? 32'h0022 : 32'h0011);
                $display("txn alt %0d: grant=%0d sum=%h", t / 3, g, resp_sum);
            end
        end
        req_valid  = 2'b00;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("alt_end_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
